pwm_multichannel: RTL and testbench

- Avalon-MM slave PWM controller driving NUM_CH independent outputs from one shared timebase.
- Successor to the fixed 32-bit pwm_out peripheral in the NIOSDuino core.
- Adds parametrised channel count and width, a prescaler, edge/center-aligned modes, per-channel polarity, and double-buffered duty/period committed at period boundaries.
- Adds a period-end interrupt; sits on the NIOS data master alongside PIO/SPI/I2C.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_multichannel_if.sv | 20 ++
 rtl/pwm_timebase.sv | 73 +++++++
 rtl/pwm_multichannel.sv | 166 ++++++++++++++++
 tb/tb_pwm_multichannel.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multichannel PWM controller: register map,
// CTRL/STATUS bit positions and the counting-mode enum.
package pwm_pkg;

  localparam int unsigned AVS_AW = 6;
  localparam int unsigned AVS_DW = 32;

  // Word addresses; bit 5 of the address selects the DUTY bank.
  localparam logic [AVS_AW-1:0] ADDR_CTRL      = 6'd0;
  localparam logic [AVS_AW-1:0] ADDR_PRESC     = 6'd1;
  localparam logic [AVS_AW-1:0] ADDR_PERIOD    = 6'd2;
  localparam logic [AVS_AW-1:0] ADDR_COMMIT    = 6'd3;
  localparam logic [AVS_AW-1:0] ADDR_STATUS    = 6'd4;
  localparam logic [AVS_AW-1:0] ADDR_POL       = 6'd5;
  localparam logic [AVS_AW-1:0] ADDR_DUTY_BASE = 6'd32;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_MODE  = 1;
  localparam int unsigned CTRL_IRQEN = 2;

  localparam int unsigned STAT_PEND = 0;
  localparam int unsigned STAT_UPD  = 1;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_multichannel_if.sv
// Avalon-MM slave bus of the PWM controller (no waitrequest, read latency 1).
//   avs_address   word address, bit 5 selects DUTY[address[4:0]]
//   avs_read      read strobe
//   avs_write     write strobe
//   avs_writedata write data
//   avs_readdata  read data, valid the cycle after avs_read
interface pwm_multichannel_if;
  import pwm_pkg::*;

  logic [AVS_AW-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [AVS_DW-1:0] avs_writedata;
  logic [AVS_DW-1:0] avs_readdata;

  modport master (output avs_address, avs_read, avs_write, avs_writedata,
                  input  avs_readdata);
  modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                  output avs_readdata);
endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/center counter and period boundary.
//   clk, rst    clock, synchronous active-high reset
//   en          run enable; prescaler and counter held at 0 while low
//   mode        active counting mode
//   presc       prescaler terminal value (tick every presc+1 clocks)
//   period      active period value
//   cnt         counter (registered)
//   boundary_c  high on the tick that brings the counter back to 0
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  pwm_mode_e          mode,
  input  logic [PRESC_W-1:0] presc,
  input  logic [CNT_W-1:0]   period,
  output logic [CNT_W-1:0]   cnt,
  output logic               boundary_c
);

  logic [PRESC_W-1:0] presc_cnt, presc_cnt_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               down, down_d;
  logic               tick_c;

  // Next prescaler/counter/direction; a boundary is any tick that lands on 0.
  always_comb begin
    presc_cnt_d = presc_cnt;
    cnt_d       = cnt;
    down_d      = down;
    tick_c      = en && (presc_cnt >= presc);
    if (!en) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
      down_d      = 1'b0;
    end else begin
      presc_cnt_d = tick_c ? '0 : presc_cnt + PRESC_W'(1);
      if (tick_c) begin
        if (mode == PWM_EDGE) begin
          cnt_d  = (cnt >= period) ? '0 : cnt + CNT_W'(1);
          down_d = 1'b0;
        end else if (down) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (cnt < period) begin
          cnt_d = cnt + CNT_W'(1);
        end else if (cnt != '0) begin
          // Turn around at the top; PERIOD=0 falls through and stays at 0.
          cnt_d  = cnt - CNT_W'(1);
          down_d = 1'b1;
        end
        if (cnt_d == '0) down_d = 1'b0;
      end
    end
    boundary_c = tick_c && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      cnt       <= '0;
      down      <= 1'b0;
    end else begin
      presc_cnt <= presc_cnt_d;
      cnt       <= cnt_d;
      down      <= down_d;
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// Avalon-MM PWM controller: NUM_CH outputs on one timebase, double-buffered
// PERIOD/DUTY/MODE committed at period boundaries, per-channel polarity.
//   clk_clk      system clock
//   reset_reset  synchronous active-high reset
//   avs          Avalon-MM slave bus
//   irq          level interrupt = STATUS.PEND & CTRL.IRQEN (registered)
//   pwm_out      registered PWM outputs
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH  = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PRESC_W = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  pwm_multichannel_if.slave avs,
  output logic              irq,
  output logic [NUM_CH-1:0] pwm_out
);

  logic               ctrl_en, ctrl_irqen;
  pwm_mode_e          mode_sh, mode_act;
  logic [PRESC_W-1:0] presc;
  logic [CNT_W-1:0]   period_sh, period_act;
  logic [CNT_W-1:0]   duty_sh  [NUM_CH];
  logic [CNT_W-1:0]   duty_act [NUM_CH];
  logic [NUM_CH-1:0]  pol;
  logic               pend, upd_pending;
  logic [AVS_DW-1:0]  rdata;

  logic [CNT_W-1:0]   cnt;
  logic               boundary_c;
  logic [NUM_CH-1:0]  raw_c;
  logic [AVS_DW-1:0]  wd_c, rd_c;
  logic [4:0]         duty_idx_c;
  logic               wr_ctrl_c, wr_presc_c, wr_period_c, wr_commit_c;
  logic               wr_status_c, wr_pol_c, wr_duty_c;
  logic               en_d, irqen_d, pend_d, upd_d, load_c;
  pwm_mode_e          mode_d;

  assign wd_c        = avs.avs_writedata;
  assign duty_idx_c  = avs.avs_address[4:0];
  assign wr_ctrl_c   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign wr_presc_c  = avs.avs_write && (avs.avs_address == ADDR_PRESC);
  assign wr_period_c = avs.avs_write && (avs.avs_address == ADDR_PERIOD);
  assign wr_commit_c = avs.avs_write && (avs.avs_address == ADDR_COMMIT);
  assign wr_status_c = avs.avs_write && (avs.avs_address == ADDR_STATUS);
  assign wr_pol_c    = avs.avs_write && (avs.avs_address == ADDR_POL);
  assign wr_duty_c   = avs.avs_write && avs.avs_address[5];

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk        (clk_clk),
    .rst        (reset_reset),
    .en         (ctrl_en),
    .mode       (mode_act),
    .presc      (presc),
    .period     (period_act),
    .cnt        (cnt),
    .boundary_c (boundary_c)
  );

  // Control/status next state; a boundary set of PEND beats a W1C, and a
  // COMMIT on the boundary cycle survives to the following boundary.
  always_comb begin
    en_d    = ctrl_en;
    irqen_d = ctrl_irqen;
    mode_d  = mode_sh;
    pend_d  = pend;
    upd_d   = upd_pending;
    if (wr_ctrl_c) begin
      en_d    = wd_c[CTRL_EN];
      irqen_d = wd_c[CTRL_IRQEN];
      mode_d  = pwm_mode_e'(wd_c[CTRL_MODE]);
    end
    if (wr_status_c && wd_c[STAT_PEND]) pend_d = 1'b0;
    if (boundary_c) pend_d = 1'b1;
    if (!ctrl_en) begin
      upd_d = 1'b0;
    end else begin
      if (boundary_c && upd_pending) upd_d = 1'b0;
      if (wr_commit_c) upd_d = 1'b1;
    end
  end

  assign load_c = !ctrl_en || (boundary_c && upd_pending);

  // Register readback (shadow values for PERIOD/DUTY).
  always_comb begin
    rd_c = '0;
    if (avs.avs_address[5]) begin
      for (int i = 0; i < NUM_CH; i++)
        if (duty_idx_c == 5'(i)) rd_c = AVS_DW'(duty_sh[i]);
    end else begin
      case (avs.avs_address)
        ADDR_CTRL: begin
          rd_c[CTRL_EN]    = ctrl_en;
          rd_c[CTRL_MODE]  = (mode_sh == PWM_CENTER);
          rd_c[CTRL_IRQEN] = ctrl_irqen;
        end
        ADDR_PRESC:  rd_c = AVS_DW'(presc);
        ADDR_PERIOD: rd_c = AVS_DW'(period_sh);
        ADDR_STATUS: begin
          rd_c[STAT_PEND] = pend;
          rd_c[STAT_UPD]  = upd_pending;
        end
        ADDR_POL:    rd_c = AVS_DW'(pol);
        default:     rd_c = '0;
      endcase
    end
  end

  // Per-channel compare against the active duty.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
    assign raw_c[i] = (cnt < duty_act[i]);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ctrl_en     <= 1'b0;
      ctrl_irqen  <= 1'b0;
      mode_sh     <= PWM_EDGE;
      mode_act    <= PWM_EDGE;
      presc       <= '0;
      period_sh   <= '0;
      period_act  <= '0;
      pol         <= '0;
      pend        <= 1'b0;
      upd_pending <= 1'b0;
      rdata       <= '0;
      irq         <= 1'b0;
      pwm_out     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      ctrl_en     <= en_d;
      ctrl_irqen  <= irqen_d;
      mode_sh     <= mode_d;
      pend        <= pend_d;
      upd_pending <= upd_d;
      if (wr_presc_c)  presc     <= wd_c[PRESC_W-1:0];
      if (wr_period_c) period_sh <= wd_c[CNT_W-1:0];
      if (wr_pol_c)    pol       <= wd_c[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++)
        if (wr_duty_c && (duty_idx_c == 5'(i))) duty_sh[i] <= wd_c[CNT_W-1:0];
      if (load_c) begin
        period_act <= period_sh;
        mode_act   <= mode_sh;
        for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
      end
      // While disabled the mode follows CTRL directly so EN+MODE can go in one write.
      if (!ctrl_en) mode_act <= mode_d;
      rdata   <= avs.avs_read ? rd_c : '0;
      irq     <= pend_d & irqen_d;
      pwm_out <= ctrl_en ? (raw_c ^ pol) : pol;
    end
  end

  assign avs.avs_readdata = rdata;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench for pwm_multichannel (NUM_CH=4, CNT_W=8). The driver
// steps a period/phase reference model and queues the expected outputs;
// a monitor pops one entry per clock and compares.
module tb_pwm_multichannel;
  import pwm_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned PW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           irq;
  logic [NCH-1:0] pwm_out;

  pwm_multichannel_if bus();

  pwm_multichannel #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .avs         (bus),
    .irq         (irq),
    .pwm_out     (pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] pwm;
    logic           irq;
    logic           rd;
    logic [31:0]    rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (register contents during the current cycle).
  bit           m_en, m_irqen, m_mode_sh, m_mode_act, m_pend, m_upd;
  int           m_presc, m_per_sh, m_per_act, m_seg;
  int           m_duty_sh[NCH];
  int           m_duty_act[NCH];
  bit [NCH-1:0] m_pol;

  // Ticks per PWM period.
  function automatic int period_ticks(int p, bit center);
    if (p == 0) return 1;
    return center ? 2 * p : p + 1;
  endfunction

  // Counter value seg clocks into a period: ramp for edge, triangle for center.
  function automatic int cnt_at(int seg, int r, int p, bit center);
    int k;
    k = seg / r;
    if (!center) return k;
    return (k <= p) ? k : 2 * p - k;
  endfunction

  function automatic bit at_boundary();
    return m_en && (m_seg == period_ticks(m_per_act, m_mode_act) * (m_presc + 1) - 1);
  endfunction

  function automatic logic [31:0] rd_model(int a);
    logic [31:0] v;
    v = '0;
    case (a)
      0: v = {29'd0, m_irqen, m_mode_sh, m_en};
      1: v = 32'(m_presc);
      2: v = 32'(m_per_sh);
      4: v = {30'd0, m_upd, m_pend};
      5: v = 32'(m_pol);
      default: if (a >= 32 && a < 32 + NCH) v = 32'(m_duty_sh[a - 32]);
    endcase
    return v;
  endfunction

  task automatic model_step(bit r, int a, bit rd, bit wr, logic [31:0] wd);
    exp_t e;
    int   c;
    bit   bnd, pend_n, upd_n, en_old;
    e = '0;
    if (r) begin
      m_en = 0; m_irqen = 0; m_mode_sh = 0; m_mode_act = 0; m_pend = 0; m_upd = 0;
      m_presc = 0; m_per_sh = 0; m_per_act = 0; m_seg = 0; m_pol = '0;
      for (int i = 0; i < NCH; i++) begin
        m_duty_sh[i] = 0;
        m_duty_act[i] = 0;
      end
      exp_q.push_back(e);
      return;
    end
    c   = cnt_at(m_seg, m_presc + 1, m_per_act, m_mode_act);
    bnd = at_boundary();
    for (int i = 0; i < NCH; i++)
      e.pwm[i] = m_en ? ((c < m_duty_act[i]) ^ m_pol[i]) : m_pol[i];
    e.rd    = rd;
    e.rdata = rd ? rd_model(a) : 32'h0;
    pend_n = m_pend;
    if (wr && a == 4 && wd[0]) pend_n = 0;
    if (bnd) pend_n = 1;
    upd_n = m_upd;
    if (!m_en) upd_n = 0;
    else begin
      if (bnd && m_upd) upd_n = 0;
      if (wr && a == 3) upd_n = 1;
    end
    if (!m_en || (bnd && m_upd)) begin
      m_per_act  = m_per_sh;
      m_mode_act = m_mode_sh;
      for (int i = 0; i < NCH; i++) m_duty_act[i] = m_duty_sh[i];
    end
    m_seg  = (!m_en || bnd) ? 0 : m_seg + 1;
    en_old = m_en;
    if (wr) begin
      case (a)
        0: begin m_en = wd[0]; m_mode_sh = wd[1]; m_irqen = wd[2]; end
        1: m_presc  = int'(wd[7:0]);
        2: m_per_sh = int'(wd[7:0]);
        5: m_pol    = wd[NCH-1:0];
        default: if (a >= 32 && a < 32 + NCH) m_duty_sh[a - 32] = int'(wd[7:0]);
      endcase
    end
    if (!en_old) m_mode_act = m_mode_sh;
    m_pend = pend_n;
    m_upd  = upd_n;
    e.irq  = m_pend & m_irqen;
    exp_q.push_back(e);
  endtask

  task automatic cyc(bit r, int a, bit rd, bit wr, logic [31:0] wd);
    @(negedge clk);
    rst               = r;
    bus.avs_address   = 6'(a);
    bus.avs_read      = rd;
    bus.avs_write     = wr;
    bus.avs_writedata = wd;
    model_step(r, a, rd, wr, wd);
  endtask

  task automatic reg_wr(int a, int d); cyc(1'b0, a, 1'b0, 1'b1, 32'(d)); endtask
  task automatic reg_rd(int a);        cyc(1'b0, a, 1'b1, 1'b0, 32'h0); endtask
  task automatic idle(int n);          repeat (n) cyc(1'b0, 0, 1'b0, 1'b0, 32'h0); endtask

  task automatic read_all();
    foreach (m_duty_sh[i]) reg_rd(32 + i);
    reg_rd(0); reg_rd(1); reg_rd(2); reg_rd(3); reg_rd(4); reg_rd(5);
  endtask

  // Idle until the next driven cycle is a period boundary.
  task automatic to_boundary();
    int guard;
    guard = 0;
    while (!at_boundary()) begin
      idle(1);
      guard++;
      if (guard > 3000) begin
        n_cmp++; n_bad++;
        $display("FAIL boundary_wait: none within %0d cycles", guard);
        return;
      end
    end
  endtask

  // Monitor: one expected entry per clock, sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        n_cmp++;
        if (pwm_out !== me.pwm) begin
          n_bad++;
          $display("FAIL pwm_out @%0t: got %b want %b", $time, pwm_out, me.pwm);
        end
        n_cmp++;
        if (irq !== me.irq) begin
          n_bad++;
          $display("FAIL irq @%0t: got %b want %b", $time, irq, me.irq);
        end
        if (me.rd) begin
          n_cmp++;
          if (bus.avs_readdata !== me.rdata) begin
            n_bad++;
            $display("FAIL readdata @%0t: got %h want %h", $time, bus.avs_readdata, me.rdata);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int per, mode, guard;
    rst = 1'b1;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    repeat (3) cyc(1'b1, 0, 1'b0, 1'b0, 32'h0);
    read_all();

    // Edge mode, PERIOD=9, DUTY0=3, IRQ on; PEND cleared now and then.
    reg_wr(1, 0); reg_wr(2, 9); reg_wr(32, 3); reg_wr(33, 9); reg_wr(34, 12);
    reg_wr(3, 0);
    reg_wr(0, 5);
    repeat (4) begin
      idle($urandom_range(5, 14));
      reg_wr(4, 1);
    end
    idle(10);

    // Shadow write without COMMIT has no effect; then COMMIT mid-period.
    reg_wr(32, 7);
    idle(30);
    reg_rd(32); reg_rd(4);
    to_boundary(); idle(4);
    reg_wr(3, 0);
    reg_rd(4);
    to_boundary(); idle(1);
    reg_rd(4);
    idle(20);

    // COMMIT landing on the boundary cycle waits a whole period.
    reg_wr(32, 2);
    to_boundary();
    reg_wr(3, 0);
    reg_rd(4);
    idle(25);

    // W1C of PEND on a boundary cycle loses to the set.
    to_boundary();
    reg_wr(4, 1);
    reg_rd(4);
    idle(3);

    // Corner duties and polarity, then disabled outputs follow POL.
    reg_wr(0, 0);
    reg_wr(32, 0); reg_wr(33, 10); reg_wr(5, 0);
    reg_wr(0, 1);
    idle(25);
    reg_wr(5, 3);
    idle(25);
    reg_wr(0, 0);
    idle(5);
    reg_wr(5, 10);
    idle(5);

    // Center mode, PERIOD=4, PRESC=1.
    reg_wr(5, 0); reg_wr(1, 1); reg_wr(2, 4); reg_wr(32, 2); reg_wr(33, 5);
    reg_wr(0, 7);
    idle(40);

    // Randomised runs with a fixed prescaler per run.
    for (int round = 0; round < 6; round++) begin
      reg_wr(0, 0);
      reg_wr(1, $urandom_range(0, 3));
      per = $urandom_range(0, 12);
      reg_wr(2, per);
      for (int i = 0; i < NCH; i++) reg_wr(32 + i, $urandom_range(0, per + 2));
      reg_wr(5, $urandom_range(0, 15));
      mode = $urandom_range(0, 1);
      reg_wr(0, 1 | (mode << 1) | 4);
      repeat (80) begin
        case ($urandom_range(0, 9))
          0: reg_wr(32 + $urandom_range(0, NCH - 1), $urandom_range(0, 14));
          1: reg_wr(2, $urandom_range(0, 12));
          2: reg_wr(3, 0);
          3: reg_wr(4, $urandom_range(0, 3));
          4, 5: reg_rd($urandom_range(0, 63));
          default: idle(1);
        endcase
      end
    end

    // Width and out-of-range channel handling.
    reg_wr(0, 0);
    reg_wr(2, 32'h1FF);
    reg_rd(2);
    reg_wr(37, 32'hAB);
    reg_rd(37);
    read_all();

    // Reset in the middle of a running period.
    reg_wr(1, 0); reg_wr(2, 9); reg_wr(32, 5); reg_wr(5, 2);
    reg_wr(0, 5);
    idle(14);
    cyc(1'b1, 0, 1'b0, 1'b0, 32'h0);
    read_all();
    idle(3);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
